// File: rtl/vx_mask_serializer_if.sv
// rtl/vx_mask_serializer_if.sv - mask-in / lane-index-out handshake bundle for vx_mask_serializer
interface vx_mask_serializer_if #(
    parameter int N         = 4,
    parameter int TAG_WIDTH = 1
);
    localparam int LOGN = (N > 1) ? $clog2(N) : 1;
    localparam int M    = $clog2(N + 1);

    logic                 valid_in;
    logic [N-1:0]         mask_in;
    logic [TAG_WIDTH-1:0] tag_in;
    logic                 ready_in;
    logic                 valid_out;
    logic [LOGN-1:0]      index_out;
    logic [TAG_WIDTH-1:0] tag_out;
    logic                 last_out;
    logic [M-1:0]         count_out;
    logic                 ready_out;

    modport master (
        output valid_in, mask_in, tag_in, ready_out,
        input  ready_in, valid_out, index_out, tag_out, last_out, count_out
    );

    modport slave (
        input  valid_in, mask_in, tag_in, ready_out,
        output ready_in, valid_out, index_out, tag_out, last_out, count_out
    );
endinterface

// File: rtl/vx_mask_serializer.sv
// rtl/vx_mask_serializer.sv - expands a lane mask into ascending set-bit indices, one per beat
module vx_mask_serializer #(
    parameter int N         = 4,
    parameter int TAG_WIDTH = 1
) (
    input logic                 clk,
    input logic                 reset,
    vx_mask_serializer_if.slave bus
);
    localparam int LOGN = (N > 1) ? $clog2(N) : 1;
    localparam int M    = $clog2(N + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state, state_n;
    logic [N-1:0]         pending, pending_n;
    logic [TAG_WIDTH-1:0] tag_q, tag_n;
    logic [M-1:0]         count_q, count_n;
    logic [LOGN-1:0]      low_idx;
    logic                 single;
    logic                 fire;
    logic                 ready;
    logic                 accept;

    function automatic logic [M-1:0] popcount(input logic [N-1:0] v);
        logic [M-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + M'(v[i]);
        end
        return c;
    endfunction

    // Scan from the top so the lowest set bit wins; an empty mask reads as index 0.
    always_comb begin
        low_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i]) begin
                low_idx = LOGN'(i);
            end
        end
    end

    assign single = (pending != '0) && ((pending & (pending - N'(1))) == '0);

    always_comb begin
        state_n   = state;
        pending_n = pending;
        tag_n     = tag_q;
        count_n   = count_q;
        fire      = (state == BUSY) & bus.ready_out;
        ready     = (state == IDLE) | (fire & single);
        accept    = bus.valid_in & ready;

        if (fire) begin
            pending_n = pending & (pending - N'(1));
            if (single) begin
                state_n = IDLE;
            end
        end

        // A new mask arriving on the last fire overrides the drain, so there is no bubble.
        if (accept) begin
            pending_n = bus.mask_in;
            tag_n     = bus.tag_in;
            count_n   = popcount(bus.mask_in);
            state_n   = (bus.mask_in != '0) ? BUSY : IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pending <= '0;
            tag_q   <= '0;
            count_q <= '0;
        end else begin
            state   <= state_n;
            pending <= pending_n;
            tag_q   <= tag_n;
            count_q <= count_n;
        end
    end

    assign bus.ready_in  = ready;
    assign bus.valid_out = (state == BUSY);
    assign bus.index_out = low_idx;
    assign bus.last_out  = single;
    assign bus.tag_out   = tag_q;
    assign bus.count_out = count_q;
endmodule

// File: tb/tb_vx_mask_serializer.sv
// tb/tb_vx_mask_serializer.sv - directed and randomized checks of vx_mask_serializer
module tb_vx_mask_serializer;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   fires;

    vx_mask_serializer_if #(.N(4),  .TAG_WIDTH(2)) m4  ();
    vx_mask_serializer_if #(.N(32), .TAG_WIDTH(1)) m32 ();
    vx_mask_serializer_if #(.N(1),  .TAG_WIDTH(1)) m1  ();

    vx_mask_serializer #(.N(4),  .TAG_WIDTH(2)) u4  (.clk(clk), .reset(reset), .bus(m4));
    vx_mask_serializer #(.N(32), .TAG_WIDTH(1)) u32 (.clk(clk), .reset(reset), .bus(m32));
    vx_mask_serializer #(.N(1),  .TAG_WIDTH(1)) u1  (.clk(clk), .reset(reset), .bus(m1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int idx;
        bit last;
    } beat_t;

    beat_t q[$];
    int    disp_count;
    int    disp_tag;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: beats are the set bits in ascending order; the highest one is last.
    task automatic push_mask(input logic [3:0] mask, input int tag);
        int pc;
        int hi;
        pc = 0;
        hi = -1;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                pc++;
                hi = i;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) q.push_back('{idx: i, last: (i == hi)});
        end
        disp_count = pc;
        disp_tag   = tag;
    endtask

    task automatic cycle4(input bit vin, input logic [3:0] mask, input logic [1:0] tag, input bit rdy);
        bit busy;
        bit exp_rdy_in;
        m4.valid_in  = vin;
        m4.mask_in   = mask;
        m4.tag_in    = tag;
        m4.ready_out = rdy;
        #1;
        busy       = (q.size() != 0);
        exp_rdy_in = !busy || (rdy && q.size() == 1);
        chk("valid_out", m4.valid_out, busy);
        chk("ready_in", m4.ready_in, exp_rdy_in);
        chk("count_out", m4.count_out, disp_count);
        chk("tag_out", m4.tag_out, disp_tag);
        if (busy) begin
            chk("index_out", m4.index_out, q[0].idx);
            chk("last_out", m4.last_out, q[0].last);
        end else begin
            chk("last_out_idle", m4.last_out, 0);
        end
        if (busy && rdy) begin
            void'(q.pop_front());
            fires++;
        end
        if (vin && exp_rdy_in) push_mask(mask, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        m4.valid_in = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        disp_count = 0;
        disp_tag   = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        fires  = 0;
        disp_count = 0;
        disp_tag   = 0;
        reset = 1'b1;
        m4.valid_in = 0;  m4.mask_in = 0;  m4.tag_in = 0;  m4.ready_out = 0;
        m32.valid_in = 0; m32.mask_in = 0; m32.tag_in = 0; m32.ready_out = 0;
        m1.valid_in = 0;  m1.mask_in = 0;  m1.tag_in = 0;  m1.ready_out = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;

        chk("rst_valid_out", m4.valid_out, 0);
        chk("rst_index_out", m4.index_out, 0);
        chk("rst_last_out", m4.last_out, 0);
        chk("rst_tag_out", m4.tag_out, 0);
        chk("rst_count_out", m4.count_out, 0);
        chk("rst_ready_in", m4.ready_in, 1);
        chk("rst32_valid_out", m32.valid_out, 0);
        chk("rst1_valid_out", m1.valid_out, 0);

        // mask 1010 tag 3 with ready_out held high
        cycle4(1, 4'b1010, 2'd3, 1);
        chk("t1_idx_a", m4.index_out, 1);
        chk("t1_last_a", m4.last_out, 0);
        chk("t1_cnt_a", m4.count_out, 2);
        chk("t1_tag_a", m4.tag_out, 3);
        cycle4(0, 4'b0000, 2'd0, 1);
        chk("t1_idx_b", m4.index_out, 3);
        chk("t1_last_b", m4.last_out, 1);
        cycle4(0, 4'b0000, 2'd0, 1);
        cycle4(0, 4'b0000, 2'd0, 1);

        // mask 1111 with ready_out toggling
        fires = 0;
        cycle4(1, 4'b1111, 2'd1, 0);
        for (int i = 0; i < 10; i++) cycle4(0, 4'b0000, 2'd0, (i % 2) == 0);
        chk("t2_fires", fires, 4);

        // zero mask then 0100
        cycle4(1, 4'b0000, 2'd2, 1);
        chk("t3_valid_after_zero", m4.valid_out, 0);
        cycle4(1, 4'b0100, 2'd1, 1);
        chk("t3_idx", m4.index_out, 2);
        chk("t3_last", m4.last_out, 1);
        chk("t3_cnt", m4.count_out, 1);
        cycle4(0, 4'b0000, 2'd0, 1);

        // back-to-back single-bit masks
        cycle4(1, 4'b1000, 2'd0, 1);
        chk("t4_idx_a", m4.index_out, 3);
        cycle4(1, 4'b0001, 2'd1, 1);
        chk("t4_idx_b", m4.index_out, 0);
        chk("t4_last_b", m4.last_out, 1);
        chk("t4_valid_b", m4.valid_out, 1);
        cycle4(0, 4'b0000, 2'd0, 1);

        // reset after the first fire of 0111
        cycle4(1, 4'b0111, 2'd2, 1);
        cycle4(0, 4'b0000, 2'd0, 1);
        pulse_reset();
        m4.ready_out = 1'b1;
        #1;
        chk("t5_valid_out", m4.valid_out, 0);
        chk("t5_ready_in", m4.ready_in, 1);
        chk("t5_count_out", m4.count_out, 0);
        repeat (3) cycle4(0, 4'b0000, 2'd0, 1);

        // randomized traffic against the reference queue
        for (int i = 0; i < 400; i++) begin
            logic [3:0] rm;
            rm = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom);
            cycle4(1'($urandom_range(0, 1)), rm, 2'($urandom), $urandom_range(0, 3) != 0);
        end
        repeat (6) cycle4(0, 4'b0000, 2'd0, 1);
        chk("rand_drained", m4.valid_out, 0);

        // N=32 and N=1 instances
        m32.valid_in = 1; m32.mask_in = 32'h8000_0001; m32.tag_in = 1; m32.ready_out = 1;
        m1.valid_in = 1;  m1.mask_in = 1'b1;           m1.tag_in = 1;  m1.ready_out = 1;
        @(posedge clk);
        #1;
        m32.valid_in = 0;
        m1.valid_in  = 0;
        #1;
        chk("n32_valid_a", m32.valid_out, 1);
        chk("n32_idx_a", m32.index_out, 0);
        chk("n32_last_a", m32.last_out, 0);
        chk("n32_cnt_a", m32.count_out, 2);
        chk("n1_valid", m1.valid_out, 1);
        chk("n1_idx", m1.index_out, 0);
        chk("n1_last", m1.last_out, 1);
        chk("n1_cnt", m1.count_out, 1);
        @(posedge clk);
        #1;
        chk("n32_idx_b", m32.index_out, 31);
        chk("n32_last_b", m32.last_out, 1);
        chk("n32_cnt_b", m32.count_out, 2);
        chk("n32_tag_b", m32.tag_out, 1);
        chk("n1_done", m1.valid_out, 0);
        @(posedge clk);
        #1;
        chk("n32_done", m32.valid_out, 0);
        chk("n32_ready_in", m32.ready_in, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
